// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, the decode->execute control bundle,
// its bubble value and the load-use FSM state encoding.
package pipe_pkg;

    localparam int REG_W  = 4;
    localparam int DATA_W = 16;
    localparam int CTRL_W = 6;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_BUBBLE = 1'b1;

    // One-bit controls travelling with an instruction; all zero means "no instruction".
    typedef struct packed {
        logic valid;
        logic re_a;
        logic re_b;
        logic we;
        logic mem_we;
        logic mem_re;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/reg_exe_hazard_stage_load_use_detect.sv
// Combinational load-use comparator: the execute-stage load writes a register
// that the decode-stage instruction is about to read.
module load_use_detect #(
    parameter int REG_W = 4
) (
    input  logic             valid_dec_i,
    input  logic             re_a_i,
    input  logic             re_b_i,
    input  logic [REG_W-1:0] ra_i,
    input  logic [REG_W-1:0] rb_i,
    input  logic             valid_exe_i,
    input  logic             mem_re_exe_i,
    input  logic             we_exe_i,
    input  logic [REG_W-1:0] robj_exe_i,
    output logic             hz_o
);

    logic match_a;
    logic match_b;

    // R0 is compared like any other register.
    assign match_a = re_a_i & (ra_i == robj_exe_i);
    assign match_b = re_b_i & (rb_i == robj_exe_i);
    assign hz_o    = valid_dec_i & valid_exe_i & mem_re_exe_i & we_exe_i & (match_a | match_b);

endmodule

// File: rtl/reg_exe_hazard_stage.sv
// Decode->execute pipeline register with load-use bubble insertion.
// Optional bubble counter enabled by defining REG_EXE_STALL_CNT_EN.
module reg_exe_hazard_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_W  = pipe_pkg::REG_W,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall_ext,
    input  logic              valid_in,
    input  logic [REG_W-1:0]  Ra_in,
    input  logic [REG_W-1:0]  Rb_in,
    input  logic              RE_A_in,
    input  logic              RE_B_in,
    input  logic [REG_W-1:0]  Robj_in,
    input  logic              WE_in,
    input  logic              mem_WE_in,
    input  logic              mem_RE_in,
    input  logic [CTRL_W-1:0] alu_ctl_in,
    input  logic [DATA_W-1:0] dA_in,
    input  logic [DATA_W-1:0] dB_in,
    output logic [REG_W-1:0]  Ra_Reg_Exe,
    output logic [REG_W-1:0]  Rb_Reg_Exe,
    output logic              RE_A_Reg_Exe,
    output logic              RE_B_Reg_Exe,
    output logic [REG_W-1:0]  Robj_Reg_Exe,
    output logic              WE_Reg_Exe,
    output logic              mem_WE_Reg_Exe,
    output logic              mem_RE_Reg_Exe,
    output logic [CTRL_W-1:0] alu_ctl_Reg_Exe,
    output logic [DATA_W-1:0] dA_Reg_Exe,
    output logic [DATA_W-1:0] dB_Reg_Exe,
    output logic              valid_Reg_Exe,
    output logic              stall_F_Reg,
    output logic [CNT_W-1:0]  stall_cnt
);

    import pipe_pkg::*;

    ctrl_t             ctrl_q,  ctrl_d;
    logic [REG_W-1:0]  ra_q,    ra_d;
    logic [REG_W-1:0]  rb_q,    rb_d;
    logic [REG_W-1:0]  robj_q,  robj_d;
    logic [CTRL_W-1:0] alu_q,   alu_d;
    logic [DATA_W-1:0] da_q,    da_d;
    logic [DATA_W-1:0] db_q,    db_d;
    logic [0:0]        state_q, state_d;
    ctrl_t             ctrl_in;
    logic              hz;

    load_use_detect #(.REG_W(REG_W)) u_detect (
        .valid_dec_i  (valid_in),
        .re_a_i       (RE_A_in),
        .re_b_i       (RE_B_in),
        .ra_i         (Ra_in),
        .rb_i         (Rb_in),
        .valid_exe_i  (ctrl_q.valid),
        .mem_re_exe_i (ctrl_q.mem_re),
        .we_exe_i     (ctrl_q.we),
        .robj_exe_i   (robj_q),
        .hz_o         (hz)
    );

    assign stall_F_Reg = (hz & ~flush) | stall_ext;

    assign ctrl_in = '{valid:  valid_in,  re_a:   RE_A_in,   re_b: RE_B_in,
                       we:     WE_in,     mem_we: mem_WE_in, mem_re: mem_RE_in};

    // Priority: flush > stall_ext > load-use bubble > normal capture.
    always_comb begin
        ctrl_d  = ctrl_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        robj_d  = robj_q;
        alu_d   = alu_q;
        da_d    = da_q;
        db_d    = db_q;
        state_d = state_q;
        if (flush || (!stall_ext && hz)) begin
            ctrl_d  = BUBBLE;
            ra_d    = '0;
            rb_d    = '0;
            robj_d  = '0;
            alu_d   = '0;
            da_d    = '0;
            db_d    = '0;
            state_d = flush ? ST_RUN : ST_BUBBLE;
        end else if (!stall_ext) begin
            ctrl_d  = ctrl_in;
            ra_d    = Ra_in;
            rb_d    = Rb_in;
            robj_d  = Robj_in;
            alu_d   = alu_ctl_in;
            da_d    = dA_in;
            db_d    = dB_in;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= BUBBLE;
            ra_q    <= '0;
            rb_q    <= '0;
            robj_q  <= '0;
            alu_q   <= '0;
            da_q    <= '0;
            db_q    <= '0;
            state_q <= ST_RUN;
        end else begin
            ctrl_q  <= ctrl_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            robj_q  <= robj_d;
            alu_q   <= alu_d;
            da_q    <= da_d;
            db_q    <= db_d;
            state_q <= state_d;
        end
    end

`ifdef REG_EXE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts only bubbles that actually get loaded; saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (!flush && !stall_ext && hz && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

    assign valid_Reg_Exe   = ctrl_q.valid;
    assign RE_A_Reg_Exe    = ctrl_q.re_a;
    assign RE_B_Reg_Exe    = ctrl_q.re_b;
    assign WE_Reg_Exe      = ctrl_q.we;
    assign mem_WE_Reg_Exe  = ctrl_q.mem_we;
    assign mem_RE_Reg_Exe  = ctrl_q.mem_re;
    assign Ra_Reg_Exe      = ra_q;
    assign Rb_Reg_Exe      = rb_q;
    assign Robj_Reg_Exe    = robj_q;
    assign alu_ctl_Reg_Exe = alu_q;
    assign dA_Reg_Exe      = da_q;
    assign dB_Reg_Exe      = db_q;

endmodule
